// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_pkg
//  Purpose  : Shared widths, FSM state type and address layout for the
//             data-cache tag-check stage.
//  Revision : 1.0
// ============================================================================
package dcache_pkg;

    localparam int ADDR_W   = 32;
    localparam int IDX_W    = 6;
    localparam int OFF_W    = 5;
    localparam int TAG_W    = ADDR_W - IDX_W - OFF_W;
    localparam int NUM_SETS = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        FILL   = 2'd3
    } tag_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [OFF_W-1:0] offset;
    } cache_addr_t;

endpackage
`default_nettype wire

// File: rtl/dcache_tag_lookup_valid_array.sv
`default_nettype none
// ============================================================================
//  Module   : valid_array
//  Purpose  : Per-set valid flops; the tag SRAM has no reset, so these gate
//             every hit. Single-set set port plus flush-all (flush wins).
//  Revision : 1.0
// ============================================================================
module valid_array
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_set_en,
    input  logic [IDX_W-1:0]    i_set_idx,
    input  logic                i_flush_all,
    output logic [NUM_SETS-1:0] o_valid
);

    logic [NUM_SETS-1:0] r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_flush_all) begin
            r_valid <= '0;
        end else if (i_set_en) begin
            r_valid[i_set_idx] <= 1'b1;
        end
    end

    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/dcache_tag_lookup.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_tag_lookup
//  Purpose  : Tag-check stage of the direct-mapped 64-set data cache; drives
//             the external tag SRAM, reports hit/miss, refills tag on miss.
//             Optional flush of all valid bits when TAG_FLUSH_EN is defined.
//  Revision : 1.0
// ============================================================================
module dcache_tag_lookup
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [IDX_W-1:0]  resp_index,
    output logic              resp_victim_valid,
    output logic [TAG_W-1:0]  resp_victim_tag,
    input  logic              fill_valid,
    input  logic              flush,
    output logic              tag_csb,
    output logic              tag_web,
    output logic [IDX_W-1:0]  tag_addr,
    output logic [TAG_W-1:0]  tag_din,
    input  logic [TAG_W-1:0]  tag_dout
);

    cache_addr_t         w_req;
    tag_state_t          r_state;
    tag_state_t          w_state_nxt;
    logic [TAG_W-1:0]    r_tag;
    logic [IDX_W-1:0]    r_idx;
    logic [NUM_SETS-1:0] w_valid_vec;
    logic                w_cur_valid;
    logic                w_hit;
    logic                w_capture;
    logic                w_set;
    logic                w_flush_now;
    logic                w_flush_block;
    logic                w_unused_offset;

    logic                r_hit_q;
    logic [IDX_W-1:0]    r_index_q;
    logic                r_vv_q;
    logic [TAG_W-1:0]    r_vt_q;

    assign w_req           = req_addr;
    assign w_unused_offset = ^w_req.offset;

    assign w_cur_valid = w_valid_vec[r_idx];
    assign w_hit       = w_cur_valid && (tag_dout == r_tag);

`ifdef TAG_FLUSH_EN
    // A flush seen outside IDLE is remembered and applied on the next IDLE.
    logic r_flush_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
        end else if (w_flush_now) begin
            r_flush_pend <= 1'b0;
        end else if (flush && (r_state != IDLE)) begin
            r_flush_pend <= 1'b1;
        end
    end

    assign w_flush_block = flush | r_flush_pend;
`else
    logic w_unused_flush;

    assign w_unused_flush = flush;
    assign w_flush_block  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        tag_csb     = 1'b1;
        tag_web     = 1'b1;
        tag_addr    = '0;
        tag_din     = '0;
        w_capture   = 1'b0;
        w_set       = 1'b0;
        w_flush_now = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_flush_block) begin
                    w_flush_now = 1'b1;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        tag_csb     = 1'b0;
                        tag_addr    = w_req.index;
                        w_capture   = 1'b1;
                        w_state_nxt = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                resp_valid = 1'b1;
                if (w_hit) begin
                    // Hit frees the stage in the same cycle for 1/clk throughput.
                    req_ready = !w_flush_block;
                    if (req_valid && !w_flush_block) begin
                        tag_csb     = 1'b0;
                        tag_addr    = w_req.index;
                        w_capture   = 1'b1;
                        w_state_nxt = LOOKUP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = MISS;
                end
            end
            MISS: begin
                if (fill_valid) begin
                    tag_csb     = 1'b0;
                    tag_web     = 1'b0;
                    tag_addr    = r_idx;
                    tag_din     = r_tag;
                    w_set       = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag <= '0;
            r_idx <= '0;
        end else if (w_capture) begin
            r_tag <= w_req.tag;
            r_idx <= w_req.index;
        end
    end

    // Result fields hold their last value between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_q   <= 1'b0;
            r_index_q <= '0;
            r_vv_q    <= 1'b0;
            r_vt_q    <= '0;
        end else if (r_state == LOOKUP) begin
            r_hit_q   <= w_hit;
            r_index_q <= r_idx;
            r_vv_q    <= w_cur_valid;
            r_vt_q    <= tag_dout;
        end
    end

    assign resp_hit          = (r_state == LOOKUP) ? w_hit       : r_hit_q;
    assign resp_index        = (r_state == LOOKUP) ? r_idx       : r_index_q;
    assign resp_victim_valid = (r_state == LOOKUP) ? w_cur_valid : r_vv_q;
    assign resp_victim_tag   = (r_state == LOOKUP) ? tag_dout    : r_vt_q;

    valid_array u_valid_array (
        .clk         (clk),
        .rst         (rst),
        .i_set_en    (w_set),
        .i_set_idx   (r_idx),
        .i_flush_all (w_flush_now),
        .o_valid     (w_valid_vec)
    );

endmodule
`default_nettype wire

// File: tb/tb_dcache_tag_lookup.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_tag_lookup
//  Purpose  : Self-checking bench with tag SRAM model, scoreboard and
//             vector table; flush scenarios built when TAG_FLUSH_EN is set.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dcache_tag_lookup;
    import dcache_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_hit;
    logic [IDX_W-1:0]  resp_index;
    logic              resp_victim_valid;
    logic [TAG_W-1:0]  resp_victim_tag;
    logic              fill_valid;
    logic              flush;
    logic              tag_csb;
    logic              tag_web;
    logic [IDX_W-1:0]  tag_addr;
    logic [TAG_W-1:0]  tag_din;
    logic [TAG_W-1:0]  tag_dout;

    int checks     = 0;
    int errors     = 0;
    int resp_count = 0;

    typedef struct {
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic             vv;
        logic [TAG_W-1:0] vt;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              exp_hit;
    } vec_t;

    exp_t             sb_q[$];
    logic             m_valid [NUM_SETS];
    logic [TAG_W-1:0] m_tag   [NUM_SETS];
    logic [TAG_W-1:0] mem     [NUM_SETS];

    dcache_tag_lookup dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .resp_valid        (resp_valid),
        .resp_hit          (resp_hit),
        .resp_index        (resp_index),
        .resp_victim_valid (resp_victim_valid),
        .resp_victim_tag   (resp_victim_tag),
        .fill_valid        (fill_valid),
        .flush             (flush),
        .tag_csb           (tag_csb),
        .tag_web           (tag_web),
        .tag_addr          (tag_addr),
        .tag_din           (tag_din),
        .tag_dout          (tag_dout)
    );

    always #5 clk = ~clk;

    // Single-port tag SRAM: read data appears after the latching edge.
    always @(posedge clk) begin
        if (tag_csb === 1'b0) begin
            if (tag_web === 1'b0) mem[tag_addr] <= tag_din;
            else                  tag_dout      <= mem[tag_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && resp_valid === 1'b1) begin
            exp_t e;
            resp_count++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=index %h required=no response", resp_index);
            end else begin
                e = sb_q.pop_front();
                chk("resp_hit", 32'(resp_hit), 32'(e.hit));
                chk("resp_index", 32'(resp_index), 32'(e.idx));
                if (!e.hit) begin
                    chk("victim_valid", 32'(resp_victim_valid), 32'(e.vv));
                    chk("victim_tag", 32'(resp_victim_tag), 32'(e.vt));
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < NUM_SETS; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_hit"}, 32'(resp_hit), 32'd0);
        chk({tag, "_resp_index"}, 32'(resp_index), 32'd0);
        chk({tag, "_victim_valid"}, 32'(resp_victim_valid), 32'd0);
        chk({tag, "_victim_tag"}, 32'(resp_victim_tag), 32'd0);
        chk({tag, "_tag_csb"}, 32'(tag_csb), 32'd1);
        chk({tag, "_tag_web"}, 32'(tag_web), 32'd1);
        chk({tag, "_tag_addr"}, 32'(tag_addr), 32'd0);
        chk({tag, "_tag_din"}, 32'(tag_din), 32'd0);
    endtask

    // Drive a request, wait (bounded) for acceptance, log expectation, return at the accepting edge.
    task automatic lookup(input logic [ADDR_W-1:0] a, input logic exp_hit, output int waited);
        exp_t             e;
        logic [IDX_W-1:0] idx;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=req_ready %b required=1 addr=%h", req_ready, a);
            req_valid = 1'b0;
            return;
        end
        idx   = a[10:5];
        e.hit = exp_hit;
        e.idx = idx;
        e.vv  = m_valid[idx];
        e.vt  = m_tag[idx];
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    // Called right after a missing lookup was accepted; optionally flushes while in MISS.
    task automatic fill(input logic [ADDR_W-1:0] a, input logic do_flush);
        int n;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("miss_ready_low", 32'(req_ready), 32'd0);
        chk("miss_sram_idle", 32'(tag_csb), 32'd1);
        if (do_flush) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        fill_valid = 1'b1;
        #1;
        chk("fill_csb", 32'(tag_csb), 32'd0);
        chk("fill_web", 32'(tag_web), 32'd0);
        chk("fill_addr", 32'(tag_addr), 32'(a[10:5]));
        chk("fill_din", 32'(tag_din), 32'(a[31:11]));
        @(negedge clk);
        fill_valid       = 1'b0;
        m_valid[a[10:5]] = 1'b1;
        m_tag[a[10:5]]   = a[31:11];
        chk("fill_bubble_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("post_fill_ready", 32'(req_ready), do_flush ? 32'd0 : 32'd1);
        if (do_flush) model_clear();
    endtask

    initial begin
        vec_t vecs[10];
        int   w, w1, w2, cnt0;

        for (int i = 0; i < NUM_SETS; i++) begin
            mem[i]   = '0;
            m_tag[i] = '0;
        end
        model_clear();
        tag_dout   = '0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        fill_valid = 1'b0;
        flush      = 1'b0;

        vecs[0] = '{32'h0000_0040, 1'b0};
        vecs[1] = '{32'h1234_5660, 1'b0};
        vecs[2] = '{32'h1234_5660, 1'b1};
        vecs[3] = '{32'h0000_0020, 1'b0};
        vecs[4] = '{32'h0010_0020, 1'b0};
        vecs[5] = '{32'h0000_0060, 1'b0};
        vecs[6] = '{32'h0000_0020, 1'b0};
        vecs[7] = '{32'h0000_07E0, 1'b0};
        vecs[8] = '{32'hFFFF_FFE0, 1'b0};
        vecs[9] = '{32'hFFFF_FFFF, 1'b1};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // First lookup: result visible in the cycle right after acceptance.
        lookup(vecs[0].addr, vecs[0].exp_hit, w);
        #1;
        chk("hit_latency_valid", 32'(resp_valid), 32'd1);
        chk("miss_ready", 32'(req_ready), 32'd0);
        fill(vecs[0].addr, 1'b0);

        for (int i = 1; i < 10; i++) begin
            lookup(vecs[i].addr, vecs[i].exp_hit, w);
            if (!vecs[i].exp_hit) fill(vecs[i].addr, 1'b0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("hold_resp_valid", 32'(resp_valid), 32'd0);
        chk("hold_resp_hit", 32'(resp_hit), 32'd1);
        chk("hold_resp_index", 32'(resp_index), 32'd63);

        // Back-to-back hits on sets 1, 2, 3.
        cnt0 = resp_count;
        lookup(32'h0000_0020, 1'b1, w);
        lookup(32'h0000_0040, 1'b1, w1);
        chk("b2b_ready_2", 32'(w1), 32'd0);
        lookup(32'h0000_0060, 1'b1, w2);
        chk("b2b_ready_3", 32'(w2), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_resp_count", 32'(resp_count - cnt0), 32'd3);

        // Reset in the middle of a miss.
        lookup(32'h0000_0100, 1'b0, w);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_in_miss");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        lookup(32'h0000_0100, 1'b0, w);
        fill(32'h0000_0100, 1'b0);
        lookup(32'h0000_0100, 1'b1, w);
        @(negedge clk);
        req_valid = 1'b0;

`ifdef TAG_FLUSH_EN
        lookup(32'h0000_00A0, 1'b0, w);
        fill(32'h0000_00A0, 1'b0);
        lookup(32'h0000_0120, 1'b0, w);
        fill(32'h0000_0120, 1'b0);
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_00A0;
        #1;
        chk("flush_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_no_accept", 32'(resp_valid), 32'd0);
        model_clear();
        lookup(32'h0000_00A0, 1'b0, w);
        fill(32'h0000_00A0, 1'b0);
        lookup(32'h0000_0120, 1'b0, w);
        fill(32'h0000_0120, 1'b0);
        lookup(32'h0000_01A0, 1'b0, w);
        fill(32'h0000_01A0, 1'b1);
        lookup(32'h0000_01A0, 1'b0, w);
        fill(32'h0000_01A0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
